// File: rtl/ram_read_cmd_arbiter.sv
// Round-robin arbiter sharing one registered read-command stream among NUM_REQ requesters.
// Chains hold the grant until a chain-end command; per-requester issued-command counters.
module ram_read_cmd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CMD_W   = 97,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk_100_clk,
  input  logic                       reset_reset_n,
  input  logic [NUM_REQ-1:0]         req_tvalid,
  input  logic [NUM_REQ*CMD_W-1:0]   req_tdata,
  output logic [NUM_REQ-1:0]         req_tready,
  output logic                       cmd_tvalid,
  output logic [CMD_W-1:0]           cmd_tdata,
  input  logic                       cmd_tready,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic [NUM_REQ*CNT_W-1:0]   issued_count
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                   r_state, w_state_nxt;
  logic [IW-1:0]            r_grant, r_last_grant, w_sel;
  logic                     w_any, w_load, w_chain_end, w_slot_free;
  logic [CMD_W-1:0]         w_gdata;
  logic                     r_cmd_tvalid;
  logic [CMD_W-1:0]         r_cmd_tdata;
  logic [NUM_REQ*CNT_W-1:0] r_count;

  // Search starts one past the last chain's owner and wraps.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && req_tvalid[IW'((32'(r_last_grant) + k) % NUM_REQ)]) begin
        w_any = 1'b1;
        w_sel = IW'((32'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant == IW'(i)) w_gdata = req_tdata[i*CMD_W +: CMD_W];
    end
  end

  assign w_slot_free = ~r_cmd_tvalid | cmd_tready;
  assign w_load      = (r_state == GRANTED) & req_tvalid[r_grant] & w_slot_free;
  assign w_chain_end = w_load & w_gdata[CMD_W-1];

  always_comb begin
    req_tready = '0;
    if (r_state == GRANTED) req_tready[r_grant] = w_slot_free;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)       w_state_nxt = GRANTED;
      GRANTED: if (w_chain_end) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_grant      <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_cmd_tvalid <= 1'b0;
      r_cmd_tdata  <= '0;
      r_count      <= '0;
    end else begin
      if (r_state == IDLE && w_any) r_grant <= w_sel;
      if (w_chain_end)              r_last_grant <= r_grant;
      // A load in the same cycle as a drain keeps the slot full with the new command.
      if (w_load) begin
        r_cmd_tvalid <= 1'b1;
        r_cmd_tdata  <= w_gdata;
      end else if (cmd_tready) begin
        r_cmd_tvalid <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_load && r_grant == IW'(i))
          r_count[i*CNT_W +: CNT_W] <= r_count[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign cmd_tvalid   = r_cmd_tvalid;
  assign cmd_tdata    = r_cmd_tdata;
  assign grant_id     = 3'(r_grant);
  assign busy         = (r_state == GRANTED) | r_cmd_tvalid;
  assign issued_count = r_count;

endmodule
